gshare_predictor: RTL and testbench

Parametrised branch direction predictor that replaces the single 2-bit saturating counter with a table of saturating counters. The table is indexed by the branch PC, optionally XOR-ed with a global history register (gshare mode). It sits beside fetch: fetch issues prediction requests, and the execute stage returns resolved outcomes to train the table. Resolution events also feed a saturating misprediction counter for performance monitoring.

---
 rtl/gshare_predictor.sv | 94 +++++++++
 tb/tb_gshare_predictor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// Gshare / bimodal branch direction predictor: a table of saturating counters indexed by
// PC (optionally XOR global history), trained by resolved outcomes, with a misprediction counter.
module gshare_predictor #(
    parameter int PC_BITS    = 8,
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int HIST_BITS  = 4,
    parameter int USE_GSHARE = 1,
    parameter int INIT_CTR   = (1 << CTR_BITS) - 1,
    parameter int MISS_BITS  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 request,
    input  logic [PC_BITS-1:0]   req_pc,
    output logic                 prediction,
    output logic                 pred_valid,
    input  logic                 result,
    input  logic [PC_BITS-1:0]   upd_pc,
    input  logic                 taken,
    output logic [MISS_BITS-1:0] miss_count,
    output logic [HIST_BITS-1:0] history
);

    localparam int                  ENTRIES  = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(INIT_CTR);

    logic [CTR_BITS-1:0]   r_table [ENTRIES];
    logic [HIST_BITS-1:0]  r_history;
    logic [MISS_BITS-1:0]  r_miss;
    logic                  r_prediction;
    logic                  r_pred_valid;

    logic [INDEX_BITS-1:0] w_hash;
    logic [INDEX_BITS-1:0] w_req_idx;
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [CTR_BITS-1:0]   w_upd_ctr;
    logic [CTR_BITS-1:0]   w_next_ctr;
    logic                  w_miss;
    logic                  w_unused_pc;

    // History is zero-extended at the MSB end before folding into the index.
    assign w_hash      = (USE_GSHARE != 0) ? INDEX_BITS'(r_history) : '0;
    assign w_req_idx   = req_pc[INDEX_BITS-1:0] ^ w_hash;
    assign w_upd_idx   = upd_pc[INDEX_BITS-1:0] ^ w_hash;
    assign w_upd_ctr   = r_table[w_upd_idx];
    assign w_miss      = w_upd_ctr[CTR_BITS-1] != taken;
    // Upper PC bits only alias into the table.
    assign w_unused_pc = ^{req_pc, upd_pc};

    always_comb begin
        // NOTE: default first so every path assigns w_next_ctr and no latch is inferred.
        w_next_ctr = w_upd_ctr;
        if (taken && (w_upd_ctr != CTR_MAX)) begin
            w_next_ctr = w_upd_ctr + CTR_BITS'(1);
        end else if (!taken && (w_upd_ctr != '0)) begin
            w_next_ctr = w_upd_ctr - CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: every counter must restart at INIT_CTR, so the table is a reset register
            // array rather than a RAM macro.
            for (int i = 0; i < ENTRIES; i++) begin
                r_table[i] <= CTR_INIT;
            end
            r_history    <= '0;
            r_miss       <= '0;
            r_prediction <= 1'b0;
            r_pred_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking updates give read-before-write when predict and train collide.
            r_pred_valid <= request;
            if (request) begin
                r_prediction <= r_table[w_req_idx][CTR_BITS-1];
            end
            if (result) begin
                r_table[w_upd_idx] <= w_next_ctr;
                r_history          <= HIST_BITS'({r_history, taken});
                if (w_miss && (r_miss != '1)) begin
                    r_miss <= r_miss + MISS_BITS'(1);
                end
            end
        end
    end

    assign prediction = r_prediction;
    assign pred_valid = r_pred_valid;
    assign miss_count = r_miss;
    assign history    = r_history;

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: gshare and bimodal instances share directed stimulus and are
// compared every cycle against a table/history model, plus hand-computed literal expectations.
module tb_gshare_predictor;

    logic       clk = 1'b0;
    logic       rst_n, request, result, taken;
    logic [7:0] req_pc, upd_pc;

    logic        pred_g, pv_g, pred_b, pv_b;
    logic [15:0] miss_g, miss_b;
    logic [3:0]  hist_g, hist_b;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state, index 0 = bimodal, 1 = gshare.
    int m_tab  [2][16];
    int m_hist [2];
    int m_miss [2];
    int m_pred [2];
    int m_pv   [2];
    bit m_live = 1'b0;

    always #5 clk = ~clk;

    gshare_predictor #(.USE_GSHARE(1)) dut_g (
        .clk(clk), .rst_n(rst_n), .request(request), .req_pc(req_pc),
        .prediction(pred_g), .pred_valid(pv_g), .result(result), .upd_pc(upd_pc),
        .taken(taken), .miss_count(miss_g), .history(hist_g)
    );

    gshare_predictor #(.USE_GSHARE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .request(request), .req_pc(req_pc),
        .prediction(pred_b), .pred_valid(pv_b), .result(result), .upd_pc(upd_pc),
        .taken(taken), .miss_count(miss_b), .history(hist_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic int idx_of(input int mode, input int pc);
        return (pc % 16) ^ (mode == 1 ? m_hist[mode] : 0);
    endfunction

    // Behaviour of one clock edge: prediction reads pre-update state, then training applies.
    task automatic model_edge(input bit rst, input bit rq, input int rp,
                              input bit rs, input int up, input bit tk);
        for (int m = 0; m < 2; m++) begin
            if (!rst) begin
                for (int e = 0; e < 16; e++) m_tab[m][e] = 3;
                m_hist[m] = 0; m_miss[m] = 0; m_pred[m] = 0; m_pv[m] = 0;
            end else begin
                int c, i;
                m_pv[m] = rq ? 1 : 0;
                if (rq) m_pred[m] = (m_tab[m][idx_of(m, rp)] >= 2) ? 1 : 0;
                if (rs) begin
                    i = idx_of(m, up);
                    c = m_tab[m][i];
                    if (((c >= 2) ? 1 : 0) != int'(tk) && m_miss[m] < 65535) m_miss[m]++;
                    if (tk && c < 3) c++;
                    else if (!tk && c > 0) c--;
                    m_tab[m][i] = c;
                    m_hist[m] = ((m_hist[m] * 2) + int'(tk)) % 16;
                end
            end
        end
        m_live = 1'b1;
    endtask

    task automatic step(input bit rst, input bit rq, input logic [7:0] rp,
                        input bit rs, input logic [7:0] up, input bit tk);
        rst_n = rst; request = rq; req_pc = rp; result = rs; upd_pc = up; taken = tk;
        @(posedge clk);
        model_edge(rst, rq, int'(rp), rs, int'(up), tk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask
    task automatic req(input logic [7:0] pc);
        step(1'b1, 1'b1, pc, 1'b0, 8'h00, 1'b0);
    endtask
    task automatic res(input logic [7:0] pc, input bit tk);
        step(1'b1, 1'b0, 8'h00, 1'b1, pc, tk);
    endtask
    task automatic idle();
        step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            check("cmp_g_pred", 32'(pred_g), 32'(m_pred[1]));
            check("cmp_g_pv",   32'(pv_g),   32'(m_pv[1]));
            check("cmp_g_miss", 32'(miss_g), 32'(m_miss[1]));
            check("cmp_g_hist", 32'(hist_g), 32'(m_hist[1]));
            check("cmp_b_pred", 32'(pred_b), 32'(m_pred[0]));
            check("cmp_b_pv",   32'(pv_b),   32'(m_pv[0]));
            check("cmp_b_miss", 32'(miss_b), 32'(m_miss[0]));
            check("cmp_b_hist", 32'(hist_b), 32'(m_hist[0]));
        end
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_pred", 32'(pred_g), 0);
        check("rst_pv",   32'(pv_g),   0);
        check("rst_miss", 32'(miss_g), 0);
        check("rst_hist", 32'(hist_g), 0);

        // First prediction from INIT_CTR, then hold on idle
        req(8'h05);
        check("first_pred", 32'(pred_g), 1);
        check("first_pv",   32'(pv_g),   1);
        idle();
        check("idle_pv",   32'(pv_g),   0);
        check("idle_hold", 32'(pred_g), 1);

        // Bimodal training down and aliasing
        res(8'h05, 1'b0);
        res(8'h05, 1'b0);
        check("bim_miss2", 32'(miss_b), 2);
        req(8'h05);
        check("bim_pred05", 32'(pred_b), 0);
        req(8'h15);
        check("bim_alias15", 32'(pred_b), 0);

        // Saturation at both ends
        do_reset();
        for (int k = 0; k < 5; k++) res(8'h03, 1'b1);
        check("sat_hi_miss", 32'(miss_b), 0);
        for (int k = 0; k < 5; k++) res(8'h03, 1'b0);
        check("sat_lo_miss", 32'(miss_b), 2);
        req(8'h03);
        check("sat_lo_pred", 32'(pred_b), 0);

        // Gshare: pre-load entry 0xF to 0, then history 1,1,0,1
        do_reset();
        for (int k = 0; k < 3; k++) res(8'h0F, 1'b0);
        res(8'h00, 1'b1);
        res(8'h00, 1'b1);
        res(8'h00, 1'b0);
        res(8'h00, 1'b1);
        check("hist_g_D", 32'(hist_g), 32'hD);
        check("hist_b_D", 32'(hist_b), 32'hD);
        check("gs_miss3", 32'(miss_g), 3);
        req(8'h02);
        check("gs_pred_F", 32'(pred_g), 0);
        req(8'h0F);
        check("gs_pred_2", 32'(pred_g), 1);

        // Reset mid-stream with request and result asserted
        step(1'b0, 1'b1, 8'h02, 1'b1, 8'h0F, 1'b0);
        check("mid_pv",   32'(pv_g),   0);
        check("mid_pred", 32'(pred_g), 0);
        check("mid_miss", 32'(miss_g), 0);
        check("mid_hist", 32'(hist_g), 0);
        for (int k = 0; k < 16; k++) begin
            req(8'(k));
            check("mid_entry_taken", 32'(pred_g), 1);
        end

        // Same-cycle predict and train on entry 0x4
        do_reset();
        res(8'h04, 1'b0);
        step(1'b1, 1'b1, 8'h04, 1'b1, 8'h04, 1'b0);
        check("conflict_pre", 32'(pred_g), 1);
        req(8'h04);
        check("conflict_post", 32'(pred_g), 0);

        idle();
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
